truncated_subtractor_stream_8bit: RTL and testbench
===================================================

# truncated_subtractor_stream_8bit

Streaming signed 8-bit lane subtractor that computes the 9-bit exact difference a − b − b0 and returns its upper 8 bits (arithmetic halving), the dropped LSB, and a per-vector sticky flag. It is the subtract/borrow counterpart of the truncated adder. It sits in the vector datapath between the operand fetch stream and the writeback stream. It provides valid/ready handshakes on both sides, one element-position counter per vector, and a 2-entry output buffer.

## Interface
- VLEN, 8: elements per vector, ≥1; sets out_last period.
- IDXW, $clog2(VLEN) (min 1): width of the element index.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  8  signed minuend.
- b  in  8  signed subtrahend.
- b0  in  1  borrow-in, subtracted as an extra 1.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts beat.
- diff_trunc  out  8  signed diff9[8:1].
- diff_lsb  out  1  diff9[0], the bit dropped by truncation.
- out_last  out  1  beat is element VLEN−1 of its vector.
- out_sticky  out  1  OR of diff_lsb over this vector's elements up to and including this beat.
- elem_idx  out  IDXW  index of next element to be accepted.

## Operation
- Arithmetic: diff9 = {a[7],a} − {b[7],b} − b0, 9-bit two's complement, exact for all inputs with no overflow. diff_trunc = diff9[8:1], which equals floor((a−b−b0)/2). Rounding is toward −∞.
- Accept: a beat is taken when in_valid && in_ready. in_ready = (count < 2). in_ready depends only on registered state, never on out_ready.
- Each accepted beat computes diff9 combinationally. It is written into the FIFO tail as {diff_trunc, diff_lsb, last, sticky}.
- Element counter: elem_idx increments on each accept. It wraps from VLEN−1 to 0.
  - last = (elem_idx == VLEN−1) at accept.
  - With VLEN=1, every beat is last and elem_idx stays 0.
- Sticky: running register run_sticky.
  - Entry sticky = run_sticky | diff_lsb, except on elem_idx==0, where it is diff_lsb alone.
  - After a last beat, run_sticky clears to 0. Otherwise it takes the entry sticky.
- Output: out_valid = (count != 0). Output fields always show the FIFO head. A pop occurs on out_valid && out_ready.
- FIFO: 2 entries with a count of 0..2.
  - Push with pop at count=1: count stays 1, and the new entry becomes head next cycle.
  - Push with pop at count=0 cannot occur.
  - At count=2 no push is possible; pop only.
- Head fields stay stable while out_valid && !out_ready. No beat is lost or duplicated.
- Reset mid-stream discards all buffered beats and any partial vector.

## Timing
- Reset values after a rst cycle: count=0, in_ready=1, out_valid=0, diff_trunc=0, diff_lsb=0, out_last=0, out_sticky=0, elem_idx=0, run_sticky=0. rst overrides any simultaneous handshake.
- Latency: a beat accepted at edge N is visible on the outputs from edge N (registered). out_valid is high in the cycle after acceptance. Minimum latency is 1 cycle.
- Throughput is 1 beat/cycle while out_ready=1.
- With out_ready held low, exactly 2 beats are accepted, then in_ready drops in the following cycle.
- in_ready rises the cycle after the first pop from a full FIFO. This is one bubble by design; there is no combinational ready path.

## Test plan
- After reset, send a=0x05, b=0x03, b0=0 with out_ready=1. Next cycle: diff_trunc=0x01, diff_lsb=0, out_last=0, out_sticky=0, elem_idx=1.
- Extremes with b0=0:
  - a=0x80, b=0x7F → diff_trunc=0x80, lsb=1.
  - a=0x7F, b=0x80 → 0x7F, lsb=1.
  - a=0x00, b=0x00, b0=1 → 0xFF, lsb=1.
  - a=0xFF, b=0xFF, b0=0 → 0x00, lsb=0.
- Backpressure: hold out_ready=0 and offer 4 beats. Only 2 are accepted and in_ready=0 thereafter. Release out_ready: beats emerge in order, unchanged while stalled, with no loss or duplication.
- VLEN=8 vector: elements 0–7 with only element 2 odd (a=3, b=0). out_sticky is 0,0,1,1,1,1,1,1 and out_last is high on element 7 only. The next vector's element 0 (even) shows sticky=0 and elem_idx returns to 0.
- Assert rst while count=2 mid-vector. Next cycle: out_valid=0, in_ready=1, elem_idx=0, and the next beat is treated as element 0.
- Run 1000 random beats with random in_valid/out_ready. A scoreboard checks diff_trunc = (a−b−b0)>>>1, diff_lsb, and out_last every VLEN beats.

Source files
------------

// File: rtl/truncated_subtractor_stream_8bit_if.sv
// Operand/result stream bundle for the truncated lane subtractor.
// The master drives operands and downstream ready; the slave is the subtractor.
interface truncated_subtractor_stream_8bit_if #(
    parameter int IDXW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic              b0;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] diff_trunc;
    logic              diff_lsb;
    logic              out_last;
    logic              out_sticky;
    logic [IDXW-1:0]   elem_idx;

    modport master (
        output in_valid, a, b, b0, out_ready,
        input  in_ready, out_valid, diff_trunc, diff_lsb, out_last, out_sticky, elem_idx
    );

    modport slave (
        input  in_valid, a, b, b0, out_ready,
        output in_ready, out_valid, diff_trunc, diff_lsb, out_last, out_sticky, elem_idx
    );
endinterface

// File: rtl/truncated_subtractor_stream_8bit.sv
// Streaming signed lane subtractor: floor((a-b-b0)/2) plus dropped LSB and per-vector sticky,
// buffered in a 2-entry output FIFO with registered-only ready.
module truncated_subtractor_stream_8bit #(
    parameter int VLEN = 8,
    parameter int IDXW = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    truncated_subtractor_stream_8bit_if.slave  bus
);
    localparam int DATA_W = 8;

    typedef struct packed {
        logic signed [DATA_W-1:0] trunc;
        logic                     lsb;
        logic                     last;
        logic                     sticky;
    } entry_t;

    function automatic logic signed [DATA_W:0] sub_exact(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y,
        input logic                     bin
    );
        logic signed [DATA_W:0] xe;
        logic signed [DATA_W:0] ye;
        logic signed [DATA_W:0] be;
        xe = x;
        ye = y;
        be = {{DATA_W{1'b0}}, bin};
        return xe - ye - be;
    endfunction

    // Dropping the LSB of a two's complement value rounds toward minus infinity.
    function automatic logic signed [DATA_W-1:0] trunc_hi(input logic signed [DATA_W:0] d);
        return d[DATA_W:1];
    endfunction

    logic [1:0]             count_q, count_d;
    entry_t                 head_q, head_d;
    entry_t                 tail_q, tail_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   run_q, run_d;

    logic                   in_ready;
    logic                   out_valid;
    logic                   accept;
    logic                   pop;
    logic signed [DATA_W:0] diff9;
    logic                   is_last;
    logic                   entry_sticky;
    entry_t                 new_entry;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign diff9        = sub_exact(bus.a, bus.b, bus.b0);
    assign is_last      = (idx_q == IDXW'(VLEN - 1));
    assign entry_sticky = (idx_q == '0) ? diff9[0] : (run_q | diff9[0]);

    always_comb begin
        new_entry.trunc  = trunc_hi(diff9);
        new_entry.lsb    = diff9[0];
        new_entry.last   = is_last;
        new_entry.sticky = entry_sticky;
    end

    always_comb begin
        idx_d = idx_q;
        run_d = run_q;
        if (accept) begin
            idx_d = is_last ? '0 : idx_q + IDXW'(1);
            run_d = is_last ? 1'b0 : entry_sticky;
        end
    end

    // Head is always the oldest beat; a push that coincides with draining the last entry goes straight to head.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (accept) begin
                    head_d  = new_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (accept && pop) begin
                    head_d = new_entry;
                end else if (accept) begin
                    tail_d  = new_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            idx_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.diff_trunc = head_q.trunc;
    assign bus.diff_lsb   = head_q.lsb;
    assign bus.out_last   = head_q.last;
    assign bus.out_sticky = head_q.sticky;
    assign bus.elem_idx   = idx_q;
endmodule

// File: tb/tb_truncated_subtractor_stream_8bit.sv
// Bench for the truncated subtractor stream: directed cases plus random traffic
// compared against a queue-based reference model.
module tb_truncated_subtractor_stream_8bit;
    localparam int VLEN = 8;
    localparam int IDXW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    truncated_subtractor_stream_8bit_if #(.IDXW(IDXW)) intf ();

    truncated_subtractor_stream_8bit #(.VLEN(VLEN), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] trunc;
        bit         lsb;
        bit         last;
        bit         sticky;
    } exp_t;

    exp_t q[$];
    int   eidx = 0;
    bit   run = 1'b0;
    int   n_acc = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: predict handshakes from pre-edge values, update model, then check post-edge state.
    task automatic cycle();
        bit   acc;
        bit   pop;
        int   d;
        exp_t e;
        acc = (intf.in_valid === 1'b1) && (intf.in_ready === 1'b1);
        pop = (intf.out_valid === 1'b1) && (intf.out_ready === 1'b1);
        if (intf.out_valid === 1'b1 && q.size() > 0 && rst === 1'b0) begin
            check("head_trunc", {24'b0, intf.diff_trunc}, {24'b0, q[0].trunc});
            check("head_lsb", {31'b0, intf.diff_lsb}, {31'b0, q[0].lsb});
            check("head_last", {31'b0, intf.out_last}, {31'b0, q[0].last});
            check("head_sticky", {31'b0, intf.out_sticky}, {31'b0, q[0].sticky});
        end
        if (rst === 1'b1) begin
            q.delete();
            eidx = 0;
            run  = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                d        = int'($signed(intf.a)) - int'($signed(intf.b)) - int'(intf.b0);
                e.trunc  = 8'(d >>> 1);
                e.lsb    = d[0];
                e.last   = (eidx == VLEN - 1);
                e.sticky = (eidx == 0) ? e.lsb : (run | e.lsb);
                run      = e.last ? 1'b0 : e.sticky;
                eidx     = (eidx + 1) % VLEN;
                q.push_back(e);
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
        check("in_ready", {31'b0, intf.in_ready}, {31'b0, (q.size() < 2)});
        check("out_valid", {31'b0, intf.out_valid}, {31'b0, (q.size() != 0)});
        check("elem_idx", 32'(intf.elem_idx), 32'(eidx));
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic bin);
        intf.in_valid = v;
        intf.a        = av;
        intf.b        = bv;
        intf.b0       = bin;
    endtask

    logic [7:0] ea  [4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [7:0] eb  [4] = '{8'h7F, 8'h80, 8'h00, 8'hFF};
    logic       eb0 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] et  [4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    logic       el  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       stv [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int n0;
        int target;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        intf.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, intf.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, intf.out_valid}, 32'd0);
        check("rst_diff_trunc", {24'b0, intf.diff_trunc}, 32'd0);
        check("rst_diff_lsb", {31'b0, intf.diff_lsb}, 32'd0);
        check("rst_out_last", {31'b0, intf.out_last}, 32'd0);
        check("rst_out_sticky", {31'b0, intf.out_sticky}, 32'd0);
        check("rst_elem_idx", 32'(intf.elem_idx), 32'd0);
        rst = 1'b0;

        drive(1'b1, 8'h05, 8'h03, 1'b0);
        intf.out_ready = 1'b1;
        cycle();
        check("first_trunc", {24'b0, intf.diff_trunc}, 32'h01);
        check("first_lsb", {31'b0, intf.diff_lsb}, 32'd0);
        check("first_last", {31'b0, intf.out_last}, 32'd0);
        check("first_sticky", {31'b0, intf.out_sticky}, 32'd0);
        check("first_elem_idx", 32'(intf.elem_idx), 32'd1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ea[i], eb[i], eb0[i]);
            cycle();
            check("extreme_trunc", {24'b0, intf.diff_trunc}, {24'b0, et[i]});
            check("extreme_lsb", {31'b0, intf.diff_lsb}, {31'b0, el[i]});
        end

        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) cycle();

        intf.out_ready = 1'b0;
        n0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(10 + 2 * i + 1), 8'h00, 1'b0);
            cycle();
        end
        check("bp_accepted", 32'(n_acc - n0), 32'd2);
        check("bp_in_ready", {31'b0, intf.in_ready}, 32'd0);
        check("bp_head_trunc", {24'b0, intf.diff_trunc}, 32'h05);
        repeat (3) cycle();
        check("bp_head_stable", {24'b0, intf.diff_trunc}, 32'h05);
        intf.out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) cycle();
        check("bp_drained", {31'b0, intf.out_valid}, 32'd0);
        check("bp_total", 32'(n_acc - n0), 32'd2);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, (k == 2) ? 8'h03 : 8'h02, 8'h00, 1'b0);
            cycle();
            check("vec_sticky", {31'b0, intf.out_sticky}, {31'b0, stv[k]});
            check("vec_last", {31'b0, intf.out_last}, {31'b0, (k == 7)});
        end
        check("vec_idx_wrap", 32'(intf.elem_idx), 32'd0);
        drive(1'b1, 8'h02, 8'h00, 1'b0);
        cycle();
        check("vec2_sticky", {31'b0, intf.out_sticky}, 32'd0);
        check("vec2_last", {31'b0, intf.out_last}, 32'd0);

        drive(1'b1, 8'h03, 8'h00, 1'b0);
        cycle();
        intf.out_ready = 1'b0;
        cycle();
        cycle();
        check("mid_full", {31'b0, intf.in_ready}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_out_valid", {31'b0, intf.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, intf.in_ready}, 32'd1);
        check("mid_rst_elem_idx", 32'(intf.elem_idx), 32'd0);
        intf.out_ready = 1'b1;
        drive(1'b1, 8'h02, 8'h00, 1'b0);
        cycle();
        check("mid_rst_sticky", {31'b0, intf.out_sticky}, 32'd0);
        check("mid_rst_last", {31'b0, intf.out_last}, 32'd0);
        check("mid_rst_next_idx", 32'(intf.elem_idx), 32'd1);

        target = n_acc + 1000;
        for (int c = 0; c < 20000 && n_acc < target; c++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
            intf.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        check("random_progress", {31'b0, (n_acc >= target)}, 32'd1);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        intf.out_ready = 1'b1;
        repeat (3) cycle();
        check("random_drained", {31'b0, intf.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
